// File: rtl/rl_output_arbiter_if.sv
// ---------------------------------------------------------------------------
// rl_output_arbiter_if
// Bundle of the arbiter handshake signals.
//
// Parameters:
//   WIDTH    flit width in bits
//   NUM_REQ  number of requesting channels
//
// Signals:
//   in_valid  [NUM_REQ]        per-requester flit valid
//   in_data   [NUM_REQ*WIDTH]  per-requester flit, requester i at [i*WIDTH +: WIDTH]
//   in_ready  [NUM_REQ]        per-requester accept
//   out_valid                  output flit valid
//   out_data  [WIDTH]          output flit
//   out_src   [$clog2(NUM_REQ)] requester that supplied out_data
//   out_ready                  downstream accept
//
// Modports:
//   master  the environment: drives requests and downstream ready
//   slave   the arbiter: accepts requests and drives the output slot
// ---------------------------------------------------------------------------
interface rl_output_arbiter_if #(
   parameter int WIDTH   = 11,
   parameter int NUM_REQ = 3
);
   localparam int SRC_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       in_valid;
   logic [NUM_REQ*WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0]       in_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [SRC_W-1:0]         out_src;
   logic                     out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/rl_output_arbiter.sv
// ---------------------------------------------------------------------------
// rl_output_arbiter
// Round-robin arbiter merging NUM_REQ routing-logic output channels into the
// single arbiter input of a router RL stage. Each requester owns a one-entry
// holding register; one held flit per cycle is granted into a registered
// output slot. Flits pass through unmodified.
//
// Parameters:
//   WIDTH    flit width (11: [0] type, [3:1] destination, [10:4] payload)
//   NUM_REQ  number of requesters (2..8)
//   CNT_W    width of each grant statistics counter
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   bus        handshake bundle (rl_output_arbiter_if.slave)
//   busy       any holding register or the output slot occupied
//   grant_cnt  per-requester saturating grant counters (ARB_STATS_EN only)
//
// Optional feature macro: ARB_STATS_EN enables the grant_cnt port/counters.
// ---------------------------------------------------------------------------
module rl_output_arbiter #(
   parameter int WIDTH   = 11,
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rl_output_arbiter_if.slave     bus,
   output logic                   busy
`ifdef ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);

   localparam int SRC_W = $clog2(NUM_REQ);

   localparam logic [0:0] SLOT_EMPTY = 1'b0;
   localparam logic [0:0] SLOT_FULL  = 1'b1;

   logic [NUM_REQ-1:0] hold_v;
   logic [WIDTH-1:0]   hold_d [NUM_REQ];
   logic [0:0]         slot_state;
   logic [WIDTH-1:0]   out_data_r;
   logic [SRC_W-1:0]   out_src_r;
   logic [SRC_W-1:0]   ptr;

   logic               slot_free;
   logic               found;
   logic               grant;
   logic [SRC_W-1:0]   winner;
   int                 idx;

   assign bus.in_ready  = ~hold_v;
   assign bus.out_valid = (slot_state == SLOT_FULL);
   assign bus.out_data  = out_data_r;
   assign bus.out_src   = out_src_r;
   assign busy          = (|hold_v) || (slot_state == SLOT_FULL);

   // The slot can take a new flit when empty or when its flit drains this edge.
   assign slot_free = (slot_state == SLOT_EMPTY) || bus.out_ready;
   assign grant     = slot_free && found;

   // Rotating-priority search: first held flit after the last winner.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && hold_v[idx]) begin
            found  = 1'b1;
            winner = SRC_W'(idx);
         end
      end
   end

   // Holding registers. A register granted this edge cannot also accept,
   // since its in_ready was low, so the two branches never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            hold_d[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (winner == SRC_W'(i))) begin
               hold_v[i] <= 1'b0;
            end else if (bus.in_valid[i] && !hold_v[i]) begin
               hold_v[i] <= 1'b1;
               hold_d[i] <= bus.in_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Output slot and priority pointer. Data and source only change on a
   // grant, so they stay steady while the slot is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_state <= SLOT_EMPTY;
         out_data_r <= '0;
         out_src_r  <= '0;
         ptr        <= SRC_W'(NUM_REQ - 1);
      end else if (slot_free) begin
         if (found) begin
            slot_state <= SLOT_FULL;
            out_data_r <= hold_d[winner];
            out_src_r  <= winner;
            ptr        <= winner;
         end else begin
            slot_state <= SLOT_EMPTY;
         end
      end
   end

`ifdef ARB_STATS_EN
   logic [CNT_W-1:0] cnt [NUM_REQ];

   // Per-requester grant counters, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (winner == SRC_W'(i)) && (cnt[i] != '1)) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
      assign grant_cnt[g*CNT_W +: CNT_W] = cnt[g];
   end
`else
   // Counters are absent; CNT_W is only referenced to keep the parameter list
   // identical between both builds.
   if (CNT_W > 0) begin : g_no_stats
   end
`endif

endmodule
